// File: rtl/rbus_pkg.sv
// Shared rbus channel widths and the arbiter state type.
package rbus_pkg;
    localparam int RBUS_DW = 72;
    localparam int RBUS_RW = 2;

    typedef enum logic [0:0] {
        OFFER = 1'b0,
        BUSY  = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rbus_rr_ptr.sv
// Round-robin pointer with an offer timer: the pointer moves on after OFFER_CYC idle
// cycles, jumps immediately on adv, and freezes while hold is set.
module rbus_rr_ptr #(
    parameter int N         = 4,
    parameter int OFFER_CYC = 4,
    parameter int PW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          hold,
    output logic [PW-1:0] ptr
);
    logic [7:0]    ocnt;
    logic [PW-1:0] ptr_nxt;

    // explicit wrap so N need not be a power of two
    assign ptr_nxt = (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            ocnt <= '0;
        end else if (adv) begin
            ptr  <= ptr_nxt;
            ocnt <= '0;
        end else if (!hold) begin
            if (ocnt == 8'(OFFER_CYC - 1)) begin
                ptr  <= ptr_nxt;
                ocnt <= '0;
            end else begin
                ocnt <= ocnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/rbus_arb_rr_nto1.sv
// Packet-atomic round-robin N-to-1 rbus arbiter: steers downstream ready to one input,
// holds the grant for a whole packet, registers forwarded words, flags protocol errors.
//
//   state | meaning
//   OFFER | input ptr sees downstream ready; waiting for its sof
//   BUSY  | forwarding ptr's packet until its first stb=0 cycle
module rbus_arb_rr_nto1
    import rbus_pkg::*;
#(
    parameter int N         = 4,
    parameter int OFFER_CYC = 4,
    parameter int MAX_LEN   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stb  [0:N-1],
    input  logic               i_sof  [0:N-1],
    input  logic [RBUS_DW-1:0] i_data [0:N-1],
    output logic [RBUS_RW-1:0] i_rdy  [0:N-1],
    output logic [RBUS_RW-1:0] i_rdyE [0:N-1],
    output logic               o_stb,
    output logic               o_sof,
    output logic [RBUS_DW-1:0] o_data,
    input  logic [RBUS_RW-1:0] o_rdy,
    input  logic [RBUS_RW-1:0] o_rdyE,
    output logic               ff_err
);
    localparam int PW = $clog2(N);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    arb_state_t         state;
    logic [PW-1:0]      ptr;
    logic [LW-1:0]      lcnt;
    logic               cur_stb;
    logic               cur_sof;
    logic [RBUS_DW-1:0] cur_data;
    logic               stray;
    logic               fwd;
    logic               fwd_sof;
    logic               err_now;
    logic               adv;
    logic               hold;

    assign cur_stb  = i_stb[ptr];
    assign cur_sof  = i_sof[ptr];
    assign cur_data = i_data[ptr];

    rbus_rr_ptr #(
        .N         (N),
        .OFFER_CYC (OFFER_CYC),
        .PW        (PW)
    ) u_rr_ptr (
        .clk  (clk),
        .rst  (rst),
        .adv  (adv),
        .hold (hold),
        .ptr  (ptr)
    );

    always_comb begin
        stray = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_stb[i] && (ptr != PW'(i))) stray = 1'b1;
        end
    end

    always_comb begin
        fwd     = 1'b0;
        fwd_sof = 1'b0;
        err_now = stray;
        adv     = 1'b0;
        hold    = 1'b0;
        if (state == OFFER) begin
            if (cur_stb && cur_sof) begin
                fwd     = 1'b1;
                fwd_sof = 1'b1;
                hold    = 1'b1;
            end else if (cur_stb) begin
                err_now = 1'b1;
            end
        end else begin
            hold = 1'b1;
            if (cur_stb) begin
                if (cur_sof) err_now = 1'b1;
                // over-length words are dropped but the packet still closes normally
                if (lcnt < LEN_MAX) fwd = 1'b1;
                else                err_now = 1'b1;
            end else begin
                adv = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= OFFER;
            lcnt   <= '0;
            o_stb  <= 1'b0;
            o_sof  <= 1'b0;
            o_data <= '0;
            ff_err <= 1'b0;
        end else begin
            o_stb <= fwd;
            o_sof <= fwd_sof;
            if (fwd)     o_data <= cur_data;
            if (err_now) ff_err <= 1'b1;
            if (state == OFFER) begin
                if (fwd) begin
                    state <= BUSY;
                    lcnt  <= LW'(1);
                end
            end else if (adv) begin
                state <= OFFER;
            end else if (fwd) begin
                lcnt <= lcnt + LW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if ((state == OFFER) && (ptr == PW'(i))) begin
                i_rdy[i]  = o_rdy;
                i_rdyE[i] = o_rdyE;
            end else begin
                i_rdy[i]  = '0;
                i_rdyE[i] = '0;
            end
        end
    end
endmodule

// File: tb/tb_rbus_arb_rr_nto1.sv
// Directed bench for rbus_arb_rr_nto1 with a per-cycle behavioural reference model.
module tb_rbus_arb_rr_nto1;
    localparam int N         = 4;
    localparam int OFFER_CYC = 4;
    localparam int MAX_LEN   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stb  [0:N-1];
    logic        i_sof  [0:N-1];
    logic [71:0] i_data [0:N-1];
    logic [1:0]  i_rdy  [0:N-1];
    logic [1:0]  i_rdyE [0:N-1];
    logic        o_stb;
    logic        o_sof;
    logic [71:0] o_data;
    logic [1:0]  o_rdy;
    logic [1:0]  o_rdyE;
    logic        ff_err;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    rbus_arb_rr_nto1 #(
        .N         (N),
        .OFFER_CYC (OFFER_CYC),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_stb  (i_stb),
        .i_sof  (i_sof),
        .i_data (i_data),
        .i_rdy  (i_rdy),
        .i_rdyE (i_rdyE),
        .o_stb  (o_stb),
        .o_sof  (o_sof),
        .o_data (o_data),
        .o_rdy  (o_rdy),
        .o_rdyE (o_rdyE),
        .ff_err (ff_err)
    );

    // reference model: who is offered, how long it has waited, packet length so far
    bit          m_started = 1'b0;
    bit          m_busy    = 1'b0;
    int          m_ptr     = 0;
    int          m_wait    = 0;
    int          m_len     = 0;
    logic        e_stb     = 1'b0;
    logic        e_sof     = 1'b0;
    logic        e_err     = 1'b0;
    logic [71:0] e_data    = '0;
    int          grants[$];

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1;
            m_busy    = 1'b0;
            m_ptr     = 0;
            m_wait    = 0;
            m_len     = 0;
            e_stb     = 1'b0;
            e_sof     = 1'b0;
            e_data    = '0;
            e_err     = 1'b0;
        end else if (m_started) begin
            e_stb = 1'b0;
            e_sof = 1'b0;
            for (int i = 0; i < N; i++) if (i_stb[i] && i != m_ptr) e_err = 1'b1;
            if (!m_busy) begin
                if (i_stb[m_ptr] && i_sof[m_ptr]) begin
                    e_stb  = 1'b1;
                    e_sof  = 1'b1;
                    e_data = i_data[m_ptr];
                    m_busy = 1'b1;
                    m_len  = 1;
                    grants.push_back(m_ptr);
                end else begin
                    if (i_stb[m_ptr]) e_err = 1'b1;
                    m_wait++;
                    if (m_wait == OFFER_CYC) begin
                        m_wait = 0;
                        m_ptr  = (m_ptr + 1) % N;
                    end
                end
            end else if (i_stb[m_ptr]) begin
                if (i_sof[m_ptr]) e_err = 1'b1;
                if (m_len < MAX_LEN) begin
                    e_stb  = 1'b1;
                    e_data = i_data[m_ptr];
                    m_len++;
                end else begin
                    e_err = 1'b1;
                end
            end else begin
                m_busy = 1'b0;
                m_wait = 0;
                m_ptr  = (m_ptr + 1) % N;
            end
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model_o_stb", 72'(o_stb), 72'(e_stb));
        chk("model_o_sof", 72'(o_sof), 72'(e_sof));
        chk("model_o_data", o_data, e_data);
        chk("model_ff_err", 72'(ff_err), 72'(e_err));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("model_i_rdy[%0d]", i), 72'(i_rdy[i]),
                72'((!m_busy && m_ptr == i) ? o_rdy : 2'b00));
            chk($sformatf("model_i_rdyE[%0d]", i), 72'(i_rdyE[i]),
                72'((!m_busy && m_ptr == i) ? o_rdyE : 2'b00));
        end
    endtask

    // outputs compared mid-cycle, inputs changed just after the rising edge
    task automatic tick();
        @(negedge clk);
        if (m_started) compare_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin
            i_stb[i]  = 1'b0;
            i_sof[i]  = 1'b0;
            i_data[i] = '0;
        end
    endtask

    task automatic drive(input int ch, input logic stb, input logic sof, input logic [71:0] d);
        i_stb[ch]  = stb;
        i_sof[ch]  = sof;
        i_data[ch] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int rem [0:1];
    int found;
    int nfwd;
    int g_base;

    initial begin
        rst    = 1'b1;
        o_rdy  = 2'b11;
        o_rdyE = 2'b01;
        idle_inputs();
        tick();
        tick();
        chk("rst_o_stb", 72'(o_stb), 72'd0);
        chk("rst_ff_err", 72'(ff_err), 72'd0);
        chk("rst_rdy0", 72'(i_rdy[0]), 72'd3);
        chk("rst_rdyE0", 72'(i_rdyE[0]), 72'd1);
        chk("rst_rdy1", 72'(i_rdy[1]), 72'd0);
        rst = 1'b0;

        // idle rotation: 4 cycles per input, then back to 0
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("idle_rdy%0d_c%0d", k / 4, k), 72'(i_rdy[k / 4]), 72'd3);
            tick();
        end
        chk("idle_wrap_rdy0", 72'(i_rdy[0]), 72'd3);
        chk("idle_o_stb", 72'(o_stb), 72'd0);

        // 5-word packet from input 2
        repeat (8) tick();
        chk("pkt2_window", 72'(i_rdy[2]), 72'd3);
        for (int w = 1; w <= 5; w++) begin
            drive(2, 1'b1, w == 1, {8'h22, 64'(w)});
            tick();
            chk("pkt2_o_stb", 72'(o_stb), 72'd1);
            chk("pkt2_o_sof", 72'(o_sof), 72'(w == 1));
            chk("pkt2_o_data", o_data, {8'h22, 64'(w)});
            chk("pkt2_busy_rdy", 72'(i_rdy[2]), 72'd0);
        end
        drive(2, 1'b0, 1'b0, '0);
        tick();
        chk("pkt2_end_stb", 72'(o_stb), 72'd0);
        chk("pkt2_next_rdy3", 72'(i_rdy[3]), 72'd3);

        // inputs 0 and 1 always have a 3-word packet waiting
        g_base = grants.size();
        rem[0] = 0;
        rem[1] = 0;
        for (int c = 0; c < 60; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (rem[s] > 0) begin
                    drive(s, 1'b1, 1'b0, {8'h30, 56'(s), 8'(c)});
                    rem[s]--;
                end else if (i_rdy[s] != 2'b00) begin
                    drive(s, 1'b1, 1'b1, {8'h30, 56'(s), 8'(c)});
                    rem[s] = 2;
                end else begin
                    drive(s, 1'b0, 1'b0, '0);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
        chk("rr_grant_count", 72'(grants.size() - g_base >= 6), 72'd1);
        for (int g = 0; g < 6; g++)
            chk($sformatf("rr_grant%0d", g),
                72'((g_base + g < grants.size()) ? grants[g_base + g] : 99), 72'(g % 2));
        chk("rr_no_err", 72'(ff_err), 72'd0);

        // stray strobe from input 3 while input 0 is offered
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (i_rdy[0] != 2'b00) found = 1;
            else tick();
        end
        chk("ptr0_offer_seen", 72'(found), 72'd1);
        chk("stray_pre_err", 72'(ff_err), 72'd0);
        drive(3, 1'b1, 1'b1, {8'h44, 64'h1});
        tick();
        idle_inputs();
        chk("stray_err_set", 72'(ff_err), 72'd1);
        chk("stray_dropped", 72'(o_stb), 72'd0);
        repeat (5) tick();
        chk("stray_err_sticky", 72'(ff_err), 72'd1);

        // 10-word packet against MAX_LEN=8
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err_clear", 72'(ff_err), 72'd0);
        nfwd = 0;
        for (int w = 1; w <= 10; w++) begin
            drive(0, 1'b1, w == 1, {8'h55, 64'(w)});
            tick();
            nfwd += int'(o_stb);
            if (w == 8) chk("maxlen_err_before", 72'(ff_err), 72'd0);
            if (w == 9) chk("maxlen_err_after", 72'(ff_err), 72'd1);
        end
        idle_inputs();
        tick();
        chk("maxlen_fwd_count", 72'(nfwd), 72'd8);
        chk("maxlen_last_data", o_data, {8'h55, 64'd8});
        chk("maxlen_offer_next", 72'(i_rdy[1]), 72'd3);

        // reset on the 3rd word of input 1's packet
        drive(1, 1'b1, 1'b1, {8'h66, 64'h1});
        tick();
        drive(1, 1'b1, 1'b0, {8'h66, 64'h2});
        tick();
        drive(1, 1'b1, 1'b0, {8'h66, 64'h3});
        rst = 1'b1;
        tick();
        chk("rstmid_o_stb", 72'(o_stb), 72'd0);
        chk("rstmid_err", 72'(ff_err), 72'd0);
        chk("rstmid_rdy0", 72'(i_rdy[0]), 72'd3);
        chk("rstmid_rdy1", 72'(i_rdy[1]), 72'd0);
        rst = 1'b0;
        idle_inputs();

        // sof on the last offer cycle wins; sof inside a packet is an error but forwarded
        repeat (3) tick();
        drive(0, 1'b1, 1'b1, {8'h77, 64'h1});
        tick();
        chk("late_sof_fwd", 72'(o_stb), 72'd1);
        chk("late_sof_osof", 72'(o_sof), 72'd1);
        chk("late_sof_hold", 72'(i_rdy[1]), 72'd0);
        drive(0, 1'b1, 1'b1, {8'h77, 64'h2});
        tick();
        chk("busy_sof_fwd", 72'(o_stb), 72'd1);
        chk("busy_sof_osof", 72'(o_sof), 72'd0);
        chk("busy_sof_data", o_data, {8'h77, 64'h2});
        chk("busy_sof_err", 72'(ff_err), 72'd1);
        idle_inputs();
        tick();
        chk("busy_sof_next", 72'(i_rdy[1]), 72'd3);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
